cpc_fdc_bus_bridge: RTL and testbench

Bridges the CPU I/O bus to the Wishbone slave port of the floppy controller wrapper. It decodes the FDC main-status/data ports and the drive motor latch. FDC accesses become single Wishbone classic cycles, and the CPU is held in wait states until the wrapper acks or a timeout expires. The block sits directly upstream of the FDC Wishbone wrapper. It also supplies that wrapper's `motor` input and the data driven back onto the CPU bus.

---
 rtl/cpc_fdc_bus_bridge.sv | 180 ++++++++++++++++++
 tb/tb_cpc_fdc_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_fdc_bus_bridge.sv
// CPU I/O bus to FDC Wishbone bridge: decodes the FDC and motor-latch ports and turns
// FDC accesses into single classic cycles while holding the CPU in wait states.
module cpc_fdc_bus_bridge #(
  parameter logic [15:0] ADDR_MASK   = 16'h0581,
  parameter logic [15:0] FDC_MATCH   = 16'h0100,
  parameter logic [15:0] MOTOR_MATCH = 16'h0000,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_doe,
  output logic        cpu_wait_n,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic [1:0]  motor,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e state_q, state_d;

  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic       adr0_q, adr0_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] dout_q, dout_d;
  logic [1:0] motor_q, motor_d;
  logic       timeout_q, timeout_d;
  logic [7:0] timer_q, timer_d;
  logic       rd_flag_q, rd_flag_d;

  logic rd_req, wr_req, any_req;
  logic fdc_hit, motor_hit;
  logic fdc_start, motor_wr, acked, expired, done;

  assign rd_req  = !cpu_iorq_n && !cpu_rd_n;
  assign wr_req  = !cpu_iorq_n && !cpu_wr_n;
  assign any_req = rd_req || wr_req;

  // addr[0] picks the FDC register, so it is excluded from the FDC match.
  assign fdc_hit   = ((cpu_addr ^ FDC_MATCH) & ADDR_MASK & 16'hFFFE) == 16'h0000;
  assign motor_hit = ((cpu_addr ^ MOTOR_MATCH) & ADDR_MASK) == 16'h0000;

  assign fdc_start = (state_q == StIdle) && fdc_hit && any_req;
  assign motor_wr  = (state_q == StIdle) && !fdc_hit && motor_hit && wr_req;
  assign acked     = (state_q == StReq) && wb_ack_i;
  // Ack takes priority over expiry on the same cycle.
  assign expired   = (state_q == StReq) && !wb_ack_i && (timer_q == TIMEOUT);
  assign done      = acked || expired;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fdc_start) begin
          state_d = StReq;
        end else if (motor_wr) begin
          state_d = StHold;
        end
      end
      StReq: begin
        // A strobe released mid-transaction skips HOLD.
        if (done) state_d = any_req ? StHold : StIdle;
      end
      StHold: begin
        if (!any_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr0_d    = adr0_q;
    dat_d     = dat_q;
    dout_d    = dout_q;
    motor_d   = motor_q;
    timeout_d = 1'b0;
    timer_d   = timer_q;
    rd_flag_d = rd_flag_q;
    if (fdc_start) begin
      cyc_d     = 1'b1;
      we_d      = wr_req;
      adr0_d    = cpu_addr[0];
      timer_d   = 8'd0;
      rd_flag_d = !wr_req;
      if (wr_req) dat_d = cpu_din;
    end
    if (motor_wr) begin
      motor_d   = {2{cpu_din[0]}};
      rd_flag_d = 1'b0;
    end
    if (state_q == StReq) begin
      timer_d = timer_q + 8'd1;
      if (acked) begin
        cyc_d = 1'b0;
        if (!we_q) dout_d = wb_dat_i;
      end else if (expired) begin
        cyc_d     = 1'b0;
        timeout_d = 1'b1;
        if (!we_q) dout_d = 8'hFF;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr0_q    <= 1'b0;
      dat_q     <= 8'h00;
      dout_q    <= 8'hFF;
      motor_q   <= 2'b00;
      timeout_q <= 1'b0;
      timer_q   <= 8'd0;
      rd_flag_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr0_q    <= adr0_d;
      dat_q     <= dat_d;
      dout_q    <= dout_d;
      motor_q   <= motor_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
      rd_flag_q <= rd_flag_d;
    end
  end

  // Wait/drive enables are combinational; reset forces their idle values immediately.
  always_comb begin
    cpu_wait_n = 1'b1;
    cpu_doe    = 1'b0;
    if (!wb_rst_i) begin
      case (state_q)
        StIdle: begin
          cpu_wait_n = !fdc_start;
          cpu_doe    = fdc_start && rd_req && !wr_req;
        end
        StReq: begin
          cpu_wait_n = 1'b0;
          cpu_doe    = !we_q;
        end
        StHold:  cpu_doe = rd_flag_q;
        default: ;
      endcase
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = {2'b00, adr0_q};
  assign wb_dat_o = dat_q;
  assign cpu_dout = dout_q;
  assign motor    = motor_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_cpc_fdc_bus_bridge.sv
// Directed bench for cpc_fdc_bus_bridge: FDC read/write, motor latch, timeout,
// ack-on-expiry and asynchronous reset mid-transaction.
module tb_cpc_fdc_bus_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [15:0] cpu_addr;
  logic        cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_doe, cpu_wait_n;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o, wb_dat_i;
  logic        wb_ack_i;
  logic [1:0]  motor;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  int stb_starts = 0;
  int to_pulses = 0;
  logic stb_prev = 1'b0;
  int s0, p0;

  cpc_fdc_bus_bridge #(
    .ADDR_MASK  (16'h0581),
    .FDC_MATCH  (16'h0100),
    .MOTOR_MATCH(16'h0000),
    .TIMEOUT    (8'd8)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cpu_addr  (cpu_addr),
    .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n  (cpu_rd_n),
    .cpu_wr_n  (cpu_wr_n),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_doe   (cpu_doe),
    .cpu_wait_n(cpu_wait_n),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .motor     (motor),
    .timeout   (timeout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    if (wb_stb_o && !stb_prev) stb_starts <= stb_starts + 1;
    if (timeout) to_pulses <= to_pulses + 1;
    stb_prev <= wb_stb_o;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic release_bus();
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    wb_dat_i = 8'h00;
    wb_ack_i = 1'b0;
    release_bus();
    #3;
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_we", wb_we_o, 1'b0);
    chk8("rst_adr", {5'b0, wb_adr_o}, 8'h00);
    chk8("rst_dat_o", wb_dat_o, 8'h00);
    chk8("rst_dout", cpu_dout, 8'hFF);
    chk1("rst_doe", cpu_doe, 1'b0);
    chk1("rst_wait_n", cpu_wait_n, 1'b1);
    chk8("rst_motor", {6'b0, motor}, 8'h00);
    chk1("rst_timeout", timeout, 1'b0);
    tick();
    wb_rst_i = 1'b0;
    tick();

    // FDC read at &FB7E, ack in cycle 2
    s0 = stb_starts;
    tick();
    cpu_addr = 16'hFB7E; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk1("rd_c0_wait_n", cpu_wait_n, 1'b0);
    chk1("rd_c0_doe", cpu_doe, 1'b1);
    chk1("rd_c0_cyc", wb_cyc_o, 1'b0);
    tick();
    chk1("rd_c1_cyc", wb_cyc_o, 1'b1);
    chk1("rd_c1_stb", wb_stb_o, 1'b1);
    chk1("rd_c1_we", wb_we_o, 1'b0);
    chk8("rd_c1_adr", {5'b0, wb_adr_o}, 8'h00);
    chk1("rd_c1_wait_n", cpu_wait_n, 1'b0);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 8'h80;
    #1;
    chk1("rd_c2_wait_n", cpu_wait_n, 1'b0);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 8'h00;
    #1;
    chk1("rd_c3_cyc", wb_cyc_o, 1'b0);
    chk8("rd_c3_dout", cpu_dout, 8'h80);
    chk1("rd_c3_wait_n", cpu_wait_n, 1'b1);
    chk1("rd_c3_doe", cpu_doe, 1'b1);
    release_bus();
    tick();
    chk1("rd_idle_doe", cpu_doe, 1'b0);
    chki("rd_stb_count", stb_starts - s0, 1);

    // Write 8'h03 to &FB7F with a 10-cycle strobe
    s0 = stb_starts;
    tick();
    cpu_addr = 16'hFB7F; cpu_din = 8'h03; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    chk1("wr_c0_wait_n", cpu_wait_n, 1'b0);
    chk1("wr_c0_doe", cpu_doe, 1'b0);
    tick();
    chk1("wr_c1_cyc", wb_cyc_o, 1'b1);
    chk1("wr_c1_we", wb_we_o, 1'b1);
    chk8("wr_c1_adr", {5'b0, wb_adr_o}, 8'h01);
    chk8("wr_c1_dat", wb_dat_o, 8'h03);
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    #1;
    chk1("wr_c3_cyc", wb_cyc_o, 1'b0);
    chk1("wr_c3_wait_n", cpu_wait_n, 1'b1);
    chk1("wr_c3_doe", cpu_doe, 1'b0);
    repeat (6) tick();
    chk1("wr_hold_cyc", wb_cyc_o, 1'b0);
    chk1("wr_hold_wait_n", cpu_wait_n, 1'b1);
    release_bus();
    tick();
    tick();
    chki("wr_stb_count", stb_starts - s0, 1);

    // Motor latch on, then off
    tick();
    cpu_addr = 16'hFA7E; cpu_din = 8'h01; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    chk1("mot_c0_wait_n", cpu_wait_n, 1'b1);
    tick();
    chk8("mot_on", {6'b0, motor}, 8'h03);
    chk1("mot_on_cyc", wb_cyc_o, 1'b0);
    chk1("mot_on_wait_n", cpu_wait_n, 1'b1);
    release_bus();
    tick();
    tick();
    cpu_din = 8'h00; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    chk8("mot_off", {6'b0, motor}, 8'h00);
    release_bus();
    tick();

    // Read with no ack: timeout after TIMEOUT+2 wait cycles
    p0 = to_pulses;
    tick();
    cpu_addr = 16'hFB7E; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk1("to_c0_wait_n", cpu_wait_n, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk1("to_wait_n", cpu_wait_n, 1'b0);
      chk1("to_cyc", wb_cyc_o, 1'b1);
      chk1("to_no_pulse", timeout, 1'b0);
    end
    tick();
    chk1("to_c10_wait_n", cpu_wait_n, 1'b1);
    chk1("to_c10_cyc", wb_cyc_o, 1'b0);
    chk1("to_c10_pulse", timeout, 1'b1);
    chk8("to_c10_dout", cpu_dout, 8'hFF);
    tick();
    chk1("to_c11_pulse", timeout, 1'b0);
    chki("to_pulse_count", to_pulses - p0, 1);
    release_bus();
    tick();

    // Ack on the exact expiry cycle
    p0 = to_pulses;
    tick();
    cpu_addr = 16'hFB7E; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (9) tick();
    wb_ack_i = 1'b1; wb_dat_i = 8'h5A;
    #1;
    chk1("ae_c9_wait_n", cpu_wait_n, 1'b0);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 8'h00;
    #1;
    chk1("ae_c10_pulse", timeout, 1'b0);
    chk8("ae_c10_dout", cpu_dout, 8'h5A);
    chk1("ae_c10_wait_n", cpu_wait_n, 1'b1);
    chk1("ae_c10_cyc", wb_cyc_o, 1'b0);
    tick();
    chki("ae_pulse_count", to_pulses - p0, 0);
    release_bus();
    tick();

    // Reset asserted mid-REQ, then a normal read
    cpu_addr = 16'hFA7E; cpu_din = 8'h01; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    release_bus();
    tick();
    cpu_addr = 16'hFB7E; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    tick();
    chk1("rr_req_cyc", wb_cyc_o, 1'b1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk1("rr_cyc", wb_cyc_o, 1'b0);
    chk1("rr_stb", wb_stb_o, 1'b0);
    chk1("rr_wait_n", cpu_wait_n, 1'b1);
    chk8("rr_motor", {6'b0, motor}, 8'h00);
    chk8("rr_dout", cpu_dout, 8'hFF);
    chk1("rr_doe", cpu_doe, 1'b0);
    tick();
    wb_rst_i = 1'b0;
    #1;
    chk1("rr2_c0_wait_n", cpu_wait_n, 1'b0);
    tick();
    chk1("rr2_c1_cyc", wb_cyc_o, 1'b1);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 8'hC3;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 8'h00;
    #1;
    chk8("rr2_dout", cpu_dout, 8'hC3);
    chk1("rr2_wait_n", cpu_wait_n, 1'b1);
    chk1("rr2_cyc", wb_cyc_o, 1'b0);
    release_bus();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
